// File: rtl/hb_interp_mc.sv
// hb_interp_mc: multi-channel 2x halfband interpolator (DUC input stage).
// Impulse response [c0 0 c1 0 .. cN-1 0.5 cN-1 .. 0 c1 0 c0] with runtime-loadable
// coefficients. Each channel owns one time-shared pre-add/multiply/accumulate lane;
// all channels share the sequencer and output control.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bypass        1: data_out follows data_in (zero-extended) every cycle
//   coeff_wr      write coeff_data into coefficient coeff_addr (0 = outermost pair)
//   stb_in        new input sample on data_in (channel j at [j*IWIDTH +: IWIDTH])
//   stb_out       output strobe, two per stb_in: even (FIR) result, then odd (centre) result
//   data_out      registered output, channel j at [j*OWIDTH +: OWIDTH]
//   busy          MAC sequence in progress
//   overrun       sticky: stb_in arrived while busy
module hb_interp_mc #(
    parameter int unsigned IWIDTH = 18,
    parameter int unsigned OWIDTH = 18,
    parameter int unsigned CWIDTH = 18,
    parameter int unsigned NPAIRS = 8,
    parameter int unsigned NCH    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bypass,
    input  logic                        coeff_wr,
    input  logic [$clog2(NPAIRS)-1:0]   coeff_addr,
    input  logic [CWIDTH-1:0]           coeff_data,
    input  logic                        stb_in,
    input  logic [NCH*IWIDTH-1:0]       data_in,
    input  logic                        stb_out,
    output logic [NCH*OWIDTH-1:0]       data_out,
    output logic                        busy,
    output logic                        overrun
);

    localparam int unsigned AW   = $clog2(NPAIRS);
    localparam int unsigned HW   = AW + 1;              // index into 2N history taps
    localparam int unsigned PW   = $clog2(NPAIRS + 1);
    localparam int unsigned SW   = IWIDTH + 1;          // pre-add width
    localparam int unsigned MW   = SW + CWIDTH;         // product width
    localparam int unsigned ACCW = MW + AW;             // N products without overflow
    localparam int unsigned GAIN = OWIDTH - IWIDTH;
    localparam int unsigned RW   = ACCW + GAIN + 1;     // headroom for scale and rounding

    localparam logic signed [RW-1:0] SAT_MAX = (RW'(1) <<< (OWIDTH - 1)) - RW'(1);
    localparam logic signed [RW-1:0] SAT_MIN = -(RW'(1) <<< (OWIDTH - 1));

    logic signed [CWIDTH-1:0] coeff_q [NPAIRS];

    logic [PW-1:0] phase_q, phase_d;
    logic [AW-1:0] issue_k, pre_k_q;
    logic [HW-1:0] hi_idx;
    logic          pre_vld_q, pre_first_q, pre_last_q;
    logic          prod_vld_q, prod_first_q, prod_last_q;
    logic          acc_done_q, odd_flag_q, overrun_q;
    logic          load_even, load_odd;

    // Pair k = phase-1 is issued; its mirror tap is h[2N-1-k].
    assign issue_k = AW'(phase_q - PW'(1));
    assign hi_idx  = HW'(2 * NPAIRS - 1) - HW'(issue_k);

    assign busy    = (phase_q != '0) || pre_vld_q || prod_vld_q || acc_done_q;
    assign overrun = overrun_q;

    // stb_in takes priority: a coincident stb_out is ignored.
    assign load_even = !bypass && stb_out && !stb_in && !odd_flag_q;
    assign load_odd  = !bypass && stb_out && !stb_in && odd_flag_q;

    always_comb begin
        phase_d = phase_q;
        if (stb_in) begin
            phase_d = PW'(1);
        end else if (phase_q == PW'(NPAIRS)) begin
            phase_d = '0;
        end else if (phase_q != '0) begin
            phase_d = phase_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= '0;
            pre_k_q      <= '0;
            pre_vld_q    <= 1'b0;
            pre_first_q  <= 1'b0;
            pre_last_q   <= 1'b0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
            prod_last_q  <= 1'b0;
            acc_done_q   <= 1'b0;
            odd_flag_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            // A new stb_in flushes the pipeline so the sequence restarts cleanly.
            pre_vld_q    <= !stb_in && (phase_q != '0);
            pre_first_q  <= (issue_k == '0);
            pre_last_q   <= (issue_k == AW'(NPAIRS - 1));
            pre_k_q      <= issue_k;
            prod_vld_q   <= !stb_in && pre_vld_q;
            prod_first_q <= pre_first_q;
            prod_last_q  <= pre_last_q;
            acc_done_q   <= !stb_in && prod_vld_q && prod_last_q;
            if (stb_in) begin
                odd_flag_q <= 1'b0;
            end else if (stb_out) begin
                odd_flag_q <= 1'b1;
            end
            if (stb_in && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPAIRS; i++) begin
                coeff_q[i] <= '0;
            end
        end else if (coeff_wr && (int'(coeff_addr) < int'(NPAIRS))) begin
            coeff_q[coeff_addr] <= coeff_data;
        end
    end

    for (genvar j = 0; j < NCH; j++) begin : g_ch
        logic signed [IWIDTH-1:0] hist_q [2*NPAIRS];
        logic signed [IWIDTH-1:0] ctr_q, tap_lo, tap_hi;
        logic signed [SW-1:0]     pre_q;
        logic signed [MW-1:0]     prod_q;
        logic signed [ACCW-1:0]   acc_q;
        logic signed [RW-1:0]     scaled, rounded;
        logic signed [OWIDTH-1:0] even_q, even_d, odd;
        logic [OWIDTH-1:0]        dout_q;
        logic [IWIDTH-1:0]        din;

        assign din    = data_in[j*IWIDTH +: IWIDTH];
        assign tap_lo = hist_q[issue_k];
        assign tap_hi = hist_q[hi_idx];
        // Centre tap is exactly 0.5 of the response, so the odd phase is a pure shift.
        assign odd    = OWIDTH'(ctr_q) <<< GAIN;

        // Round half up, then clamp to the output range.
        always_comb begin
            scaled  = RW'(acc_q) <<< GAIN;
            rounded = (scaled + (RW'(1) <<< (CWIDTH - 3))) >>> (CWIDTH - 2);
            even_d  = OWIDTH'(rounded);
            if (rounded > SAT_MAX) begin
                even_d = OWIDTH'(SAT_MAX);
            end else if (rounded < SAT_MIN) begin
                even_d = OWIDTH'(SAT_MIN);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < 2 * NPAIRS; i++) begin
                    hist_q[i] <= '0;
                end
                ctr_q  <= '0;
                pre_q  <= '0;
                prod_q <= '0;
                acc_q  <= '0;
                even_q <= '0;
                dout_q <= '0;
            end else begin
                if (stb_in) begin
                    hist_q[0] <= din;
                    for (int i = 1; i < 2 * NPAIRS; i++) begin
                        hist_q[i] <= hist_q[i-1];
                    end
                    ctr_q <= hist_q[NPAIRS-2];
                end
                pre_q  <= {tap_lo[IWIDTH-1], tap_lo} + {tap_hi[IWIDTH-1], tap_hi};
                prod_q <= MW'(pre_q) * MW'(coeff_q[pre_k_q]);
                if (prod_vld_q) begin
                    acc_q <= prod_first_q ? ACCW'(prod_q) : acc_q + ACCW'(prod_q);
                end
                if (acc_done_q) begin
                    even_q <= even_d;
                end
                if (bypass) begin
                    dout_q <= OWIDTH'(din);
                end else if (load_even) begin
                    dout_q <= even_q;
                end else if (load_odd) begin
                    dout_q <= odd;
                end
            end
        end

        assign data_out[j*OWIDTH +: OWIDTH] = dout_q;
    end

endmodule

// File: tb/tb_hb_interp_mc.sv
// Directed testbench for hb_interp_mc with N=4, NCH=2. Two instances share all inputs:
// dut (OWIDTH=18) and dut_w (OWIDTH=24, six bits of gain on every path).
module tb_hb_interp_mc;

    logic        clk = 1'b0;
    logic        rst, bypass, coeff_wr, stb_in, stb_out;
    logic [1:0]  coeff_addr;
    logic [17:0] coeff_data;
    logic [35:0] data_in;
    logic [35:0] data_out;
    logic [47:0] data_out_w;
    logic        busy, overrun, busy_w, overrun_w;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint ev0, od0, ev1, od1, evw0, odw0, evw1, odw1;

    always #5 clk = ~clk;

    hb_interp_mc #(
        .IWIDTH(18), .OWIDTH(18), .CWIDTH(18), .NPAIRS(4), .NCH(2)
    ) dut (
        .clk(clk), .rst(rst), .bypass(bypass), .coeff_wr(coeff_wr),
        .coeff_addr(coeff_addr), .coeff_data(coeff_data), .stb_in(stb_in),
        .data_in(data_in), .stb_out(stb_out), .data_out(data_out),
        .busy(busy), .overrun(overrun)
    );

    hb_interp_mc #(
        .IWIDTH(18), .OWIDTH(24), .CWIDTH(18), .NPAIRS(4), .NCH(2)
    ) dut_w (
        .clk(clk), .rst(rst), .bypass(bypass), .coeff_wr(coeff_wr),
        .coeff_addr(coeff_addr), .coeff_data(coeff_data), .stb_in(stb_in),
        .data_in(data_in), .stb_out(stb_out), .data_out(data_out_w),
        .busy(busy_w), .overrun(overrun_w)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint s18(input logic [17:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint s24(input logic [23:0] v);
        return longint'($signed(v));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic load4(input int c0, input int c1, input int c2, input int c3);
        int c [4];
        c = '{c0, c1, c2, c3};
        for (int k = 0; k < 4; k++) begin
            coeff_wr   = 1'b1;
            coeff_addr = 2'(k);
            coeff_data = 18'(c[k]);
            tick();
        end
        coeff_wr = 1'b0;
    endtask

    task automatic send(input int x0, input int x1);
        stb_in  = 1'b1;
        data_in = {18'(x1), 18'(x0)};
        tick();
        stb_in  = 1'b0;
        data_in = '0;
    endtask

    // One input sample, then the two output strobes at cycles 8 and 9 (first legal slot).
    task automatic samp(input int x0, input int x1);
        send(x0, x1);
        idle(7);
        stb_out = 1'b1;
        tick();
        ev0  = s18(data_out[17:0]);
        ev1  = s18(data_out[35:18]);
        evw0 = s24(data_out_w[23:0]);
        evw1 = s24(data_out_w[47:24]);
        tick();
        stb_out = 1'b0;
        od0  = s18(data_out[17:0]);
        od1  = s18(data_out[35:18]);
        odw0 = s24(data_out_w[23:0]);
        odw1 = s24(data_out_w[47:24]);
    endtask

    initial begin
        int exp_e [6];
        int exp_o [6];
        exp_e = '{0, 0, 0, 500, 500, 0};
        exp_o = '{0, 0, 0, 1000, 0, 0};

        rst = 1'b1; bypass = 1'b0; coeff_wr = 1'b0; coeff_addr = '0; coeff_data = '0;
        stb_in = 1'b0; stb_out = 1'b0; data_in = '0;
        idle(3);
        rst = 1'b0;
        check_eq("init_dout", longint'(data_out), 0);
        check_eq("init_busy", longint'(busy), 0);
        check_eq("init_overrun", longint'(overrun), 0);

        // Reset in the middle of a sequence
        load4(0, 0, 0, 32768);
        for (int i = 0; i < 4; i++) samp(1000, 0);
        check_eq("pre_rst_even", ev0, 500);
        check_eq("pre_rst_odd", od0, 1000);
        send(1000, 0);
        idle(2);
        check_eq("phase3_busy", longint'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_dout", longint'(data_out), 0);
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_overrun", longint'(overrun), 0);
        load4(0, 0, 0, 32768);
        samp(0, 0);
        check_eq("rst_hist_even", ev0, 0);
        check_eq("rst_hist_odd", od0, 0);

        // Impulse on ch0; dut_w carries the same response scaled by 64
        for (int i = 0; i < 6; i++) begin
            samp((i == 0) ? 1000 : 0, 0);
            check_eq($sformatf("imp_even0_%0d", i), ev0, exp_e[i]);
            check_eq($sformatf("imp_odd0_%0d", i), od0, exp_o[i]);
            check_eq($sformatf("imp_even1_%0d", i), ev1, 0);
            check_eq($sformatf("imp_odd1_%0d", i), od1, 0);
            check_eq($sformatf("imp_w_even0_%0d", i), evw0, 64 * exp_e[i]);
            check_eq($sformatf("imp_w_odd0_%0d", i), odw0, 64 * exp_o[i]);
        end
        check_eq("imp_overrun", longint'(overrun), 0);

        // Unity DC gain
        load4(-1000, 3000, -6000, 36768);
        for (int i = 0; i < 8; i++) samp(10000, 10000);
        check_eq("dc_even0", ev0, 10000);
        check_eq("dc_odd0", od0, 10000);
        check_eq("dc_even1", ev1, 10000);
        check_eq("dc_odd1", od1, 10000);
        check_eq("dc_w_even0", evw0, 640000);
        check_eq("dc_w_odd1", odw1, 640000);

        // Saturation at both rails
        load4(0, 0, 0, 131071);
        for (int i = 0; i < 5; i++) samp(131071, -131072);
        check_eq("sat_even_pos", ev0, 131071);
        check_eq("sat_even_neg", ev1, -131072);
        check_eq("sat_odd_pos", od0, 131071);
        check_eq("sat_odd_neg", od1, -131072);
        check_eq("sat_w_even_pos", evw0, 8388607);
        check_eq("sat_w_even_neg", evw1, -8388608);

        // Overrun: spacing 6 trips it, spacing 8 does not
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(1, 1);
        idle(5);
        check_eq("ovr_before", longint'(overrun), 0);
        send(1, 1);
        check_eq("ovr_set", longint'(overrun), 1);
        check_eq("ovr_set_w", longint'(overrun_w), 1);
        idle(20);
        check_eq("ovr_sticky", longint'(overrun), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("ovr_cleared", longint'(overrun), 0);
        for (int i = 0; i < 3; i++) begin
            send(1, 1);
            idle(7);
        end
        check_eq("ovr_min_spacing", longint'(overrun), 0);

        // Bypass, zero-extended into the wider output
        bypass  = 1'b1;
        data_in = {18'(0), 18'(-5)};
        tick();
        check_eq("byp_w_ch0", longint'(data_out_w[23:0]), 'h03FFFB);
        check_eq("byp_ch0", longint'(data_out[17:0]), 'h3FFFB);
        check_eq("byp_ch1", longint'(data_out[35:18]), 0);
        bypass  = 1'b0;
        data_in = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
